teclado_cajero: RTL and testbench
=================================

# teclado_cajero

Keypad front-end for the ATM controller. Debounces raw key presses and delivers the controller's input handshakes. In PIN mode it issues `DIGITO`/`DIGITO_STB`. In amount mode it accumulates decimal digits into a binary `MONTO` and commits it with `MONTO_STB` on ENTER. It sits directly upstream of the ATM transaction controller and drives its `DIGITO`, `DIGITO_STB`, `MONTO` and `MONTO_STB` inputs.

## Interface
- `DEBOUNCE_CICLOS`, 4: consecutive identical samples required to accept a press or a release; legal range 2..15.
- `MAX_DIGITOS_MONTO`, 9: maximum amount digits; legal range 1..9, so the accumulator never exceeds 32 bits.
- `CLK`  in  1: single clock; all logic on the rising edge.
- `RESET`  in  1: synchronous, active-high.
- `TECLA_VALIDA`  in  1: high while a key is held; already synchronised to `CLK`.
- `TECLA`  in  4: key code. 0–9 are digits, 4'hA is ENTER, 4'hB is BORRAR, 4'hC–4'hF are ignored keys.
- `MODO_MONTO`  in  1: 0 selects PIN entry, 1 selects amount entry; driven by the controller.
- `DIGITO`  out  4: last accepted PIN digit.
- `DIGITO_STB`  out  1: one-cycle strobe, valid with `DIGITO`.
- `MONTO`  out  32: last committed amount, binary.
- `MONTO_STB`  out  1: one-cycle strobe, valid with `MONTO`.
- `MONTO_DESBORDE`  out  1: high while a digit has been rejected because the digit limit was reached.
- `NUM_DIGITOS`  out  4: digit count in the current amount accumulator.

## Operation
- **Debounce FSM states**
  - LIBRE: waiting for a press.
  - FILTRO_PRESION: counting stable press samples.
  - PRESIONADA: press accepted, waiting for release.
  - FILTRO_LIBERACION: counting stable release samples.
- **Debounce FSM transitions**
  - LIBRE→FILTRO_PRESION when `TECLA_VALIDA`=1; latch `TECLA` and set the counter to 1.
  - In FILTRO_PRESION, the counter increments while `TECLA_VALIDA`=1 and the code equals the latched code.
  - In FILTRO_PRESION, a code change restarts the filter with the new code (counter to 1).
  - In FILTRO_PRESION, `TECLA_VALIDA`=0 returns to LIBRE.
  - On the `DEBOUNCE_CICLOS`-th consecutive sample: accept the key and go to PRESIONADA.
  - PRESIONADA→FILTRO_LIBERACION when `TECLA_VALIDA`=0. Code changes while held are ignored.
  - In FILTRO_LIBERACION, `TECLA_VALIDA`=1 returns to PRESIONADA (a bounce) with no new acceptance.
  - After `DEBOUNCE_CICLOS` consecutive low samples, go to LIBRE.
- **Acceptance actions** use the value of `MODO_MONTO` sampled at the acceptance edge.
- **PIN mode** (`MODO_MONTO`=0)
  - Digit: `DIGITO`←code and pulse `DIGITO_STB`.
  - ENTER, BORRAR and ignored keys: no effect.
  - The amount accumulator, `NUM_DIGITOS` and `MONTO_DESBORDE` are held at 0 while `MODO_MONTO`=0.
- **Amount mode** (`MODO_MONTO`=1)
  - Digit with `NUM_DIGITOS` < `MAX_DIGITOS_MONTO`: acc←acc*10+d, computed at 36-bit width and truncated to 32; `NUM_DIGITOS`++.
  - Digit at the limit: acc is unchanged and `MONTO_DESBORDE`←1.
  - ENTER with `NUM_DIGITOS`>0: `MONTO`←acc, pulse `MONTO_STB`, then clear acc, `NUM_DIGITOS` and `MONTO_DESBORDE`.
  - ENTER with `NUM_DIGITOS`=0: ignored, no strobe.
  - BORRAR: clear acc, `NUM_DIGITOS` and `MONTO_DESBORDE`.
  - Leading zeros count as digits: "0","5",ENTER gives `MONTO`=5.
  - `DIGITO_STB` never asserts in amount mode.

## Timing
- **Reset values:** all outputs 0, FSM in LIBRE, counter and accumulator 0.
- **Reset mid-operation:** everything is aborted and no strobe is generated. A key still held after `RESET` falls is filtered as a new press.
- **Acceptance latency:** with samples at edges E0..E(N-1) all stable, the strobe is high during the cycle between edges E(N-1) and E(N), where N = `DEBOUNCE_CICLOS`.
- **Strobe width:** exactly one cycle per accepted key. There are no back-to-back strobes, because the release filter must complete first.
- **Minimum spacing** between two accepted presses: 2·N cycles.
- **Data validity:** `DIGITO` and `MONTO` are stable from the strobe cycle until the next acceptance of the same kind.
- **No flow control:** the consumer must sample each strobe.
- **Mode changes:**
  - `MODO_MONTO` switching 1→0 clears the accumulator on the next edge with no strobe.
  - A switch coinciding with an acceptance edge uses the sampled mode for the action. A clear caused by `MODO_MONTO`=0 wins over an accumulate.

## Structure
- Shared package `cajero_pkg`:
  - key code constants `TECLA_ENTER`=4'hA and `TECLA_BORRAR`=4'hB;
  - debounce state encoding;
  - the 32-bit amount width constant shared with the controller.
- Sub-module `antirrebote_tecla`: the debounce FSM and counter. It outputs a one-cycle `tecla_aceptada` and the latched 4-bit code. The top level holds only the mode decode, accumulator and output registers.

## Test plan
- **Clean PIN entry:** `DEBOUNCE_CICLOS`=4, mode 0, keys 3,5,6,6 each held 6 cycles with 6 cycles released → four single-cycle `DIGITO_STB` with `DIGITO`=3,5,6,6, each 4 edges after press onset.
- **Bounce rejection:**
  - Press 7 toggling valid 1,0,1,0 and then stable → exactly one strobe with `DIGITO`=7.
  - A 2-cycle release glitch while held → no second strobe.
- **Amount commit:** mode 1, keys 1,0,0,0,0,ENTER → `MONTO_STB` once, `MONTO`=10000, then `NUM_DIGITOS`=0.
- **Limit and clear:**
  - Ten 9s → `MONTO_DESBORDE`=1 and acc 999999999; ENTER → `MONTO`=999999999 and the flag clears.
  - "4",BORRAR,ENTER → no strobe.
- **Mode switching:** "7","0" in mode 1, switch to mode 0, then ENTER → no `MONTO_STB`, no `DIGITO_STB`, `MONTO` keeps its previous value.
- **Reset:**
  - `RESET` asserted one edge before acceptance → no strobe, outputs 0.
  - Key held through reset → one strobe N edges after `RESET` falls.

Source files
------------

// File: rtl/cajero_pkg.sv
// Shared definitions between the ATM keypad front-end and the transaction controller:
// key codes, debounce state encoding and the amount width.
package cajero_pkg;

   localparam int unsigned ANCHO_MONTO = 32;

   localparam logic [3:0] TECLA_ENTER  = 4'hA;
   localparam logic [3:0] TECLA_BORRAR = 4'hB;

   typedef enum logic [1:0] {
      LIBRE             = 2'd0,
      FILTRO_PRESION    = 2'd1,
      PRESIONADA        = 2'd2,
      FILTRO_LIBERACION = 2'd3
   } estado_antirrebote_t;

   function automatic logic es_digito(input logic [3:0] codigo);
      return (codigo <= 4'd9);
   endfunction

endpackage

// File: rtl/antirrebote_tecla.sv
// Debounce FSM for the keypad: filters press and release, and flags a key
// as accepted for exactly one cycle, ending at the acceptance edge.
module antirrebote_tecla
   import cajero_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CICLOS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tecla_valida,
   input  logic [3:0] tecla,
   output logic       tecla_aceptada,
   output logic [3:0] tecla_codigo
);

   localparam logic [3:0] ULTIMA_MUESTRA = 4'(DEBOUNCE_CICLOS - 1);

   estado_antirrebote_t estado, estado_sig;
   logic [3:0]          contador, contador_sig;
   logic [3:0]          codigo, codigo_sig;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= LIBRE;
         contador <= 4'd0;
         codigo   <= 4'd0;
      end else begin
         estado   <= estado_sig;
         contador <= contador_sig;
         codigo   <= codigo_sig;
      end
   end

   // The counter holds the number of stable samples already seen, so the
   // N-th sample is the one that finds it at N-1.
   always_comb begin
      estado_sig     = estado;
      contador_sig   = contador;
      codigo_sig     = codigo;
      tecla_aceptada = 1'b0;
      case (estado)
         LIBRE: begin
            if (tecla_valida) begin
               estado_sig   = FILTRO_PRESION;
               codigo_sig   = tecla;
               contador_sig = 4'd1;
            end
         end
         FILTRO_PRESION: begin
            if (!tecla_valida) begin
               estado_sig   = LIBRE;
               contador_sig = 4'd0;
            end else if (tecla != codigo) begin
               codigo_sig   = tecla;
               contador_sig = 4'd1;
            end else if (contador == ULTIMA_MUESTRA) begin
               estado_sig     = PRESIONADA;
               contador_sig   = 4'd0;
               tecla_aceptada = 1'b1;
            end else begin
               contador_sig = contador + 4'd1;
            end
         end
         PRESIONADA: begin
            if (!tecla_valida) begin
               estado_sig   = FILTRO_LIBERACION;
               contador_sig = 4'd1;
            end
         end
         FILTRO_LIBERACION: begin
            if (tecla_valida) begin
               estado_sig   = PRESIONADA;
               contador_sig = 4'd0;
            end else if (contador == ULTIMA_MUESTRA) begin
               estado_sig   = LIBRE;
               contador_sig = 4'd0;
            end else begin
               contador_sig = contador + 4'd1;
            end
         end
         default: begin
            estado_sig   = LIBRE;
            contador_sig = 4'd0;
         end
      endcase
   end

   assign tecla_codigo = codigo;

endmodule

// File: rtl/teclado_cajero.sv
// Keypad front-end for the ATM controller: PIN digits are forwarded one by one,
// amount digits are accumulated in binary and committed on ENTER.
module teclado_cajero
   import cajero_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CICLOS   = 4,
   parameter int unsigned MAX_DIGITOS_MONTO = 9
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   TECLA_VALIDA,
   input  logic [3:0]             TECLA,
   input  logic                   MODO_MONTO,
   output logic [3:0]             DIGITO,
   output logic                   DIGITO_STB,
   output logic [ANCHO_MONTO-1:0] MONTO,
   output logic                   MONTO_STB,
   output logic                   MONTO_DESBORDE,
   output logic [3:0]             NUM_DIGITOS
);

   localparam logic [3:0] LIMITE_DIGITOS = 4'(MAX_DIGITOS_MONTO);

   logic                   tecla_aceptada;
   logic [3:0]             tecla_codigo;
   logic [ANCHO_MONTO-1:0] acumulador;
   logic [ANCHO_MONTO+3:0] acumulador_ext;
   logic [ANCHO_MONTO+3:0] acumulado_sig;

   antirrebote_tecla #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
   ) u_antirrebote (
      .clk           (CLK),
      .reset         (RESET),
      .tecla_valida  (TECLA_VALIDA),
      .tecla         (TECLA),
      .tecla_aceptada(tecla_aceptada),
      .tecla_codigo  (tecla_codigo)
   );

   // acc*10 + d as (acc<<3)+(acc<<1)+d, kept 4 bits wider than the amount.
   assign acumulador_ext = {4'd0, acumulador};
   assign acumulado_sig  = (acumulador_ext << 3) + (acumulador_ext << 1)
                         + {{ANCHO_MONTO{1'b0}}, tecla_codigo};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         DIGITO         <= 4'd0;
         DIGITO_STB     <= 1'b0;
         MONTO          <= '0;
         MONTO_STB      <= 1'b0;
         MONTO_DESBORDE <= 1'b0;
         NUM_DIGITOS    <= 4'd0;
         acumulador     <= '0;
      end else begin
         DIGITO_STB <= 1'b0;
         MONTO_STB  <= 1'b0;
         // PIN mode keeps the amount path cleared, which also handles 1->0 switches.
         if (!MODO_MONTO) begin
            acumulador     <= '0;
            NUM_DIGITOS    <= 4'd0;
            MONTO_DESBORDE <= 1'b0;
            if (tecla_aceptada && es_digito(tecla_codigo)) begin
               DIGITO     <= tecla_codigo;
               DIGITO_STB <= 1'b1;
            end
         end else if (tecla_aceptada) begin
            if (es_digito(tecla_codigo)) begin
               if (NUM_DIGITOS < LIMITE_DIGITOS) begin
                  acumulador  <= acumulado_sig[ANCHO_MONTO-1:0];
                  NUM_DIGITOS <= NUM_DIGITOS + 4'd1;
               end else begin
                  MONTO_DESBORDE <= 1'b1;
               end
            end else if (tecla_codigo == TECLA_ENTER) begin
               if (NUM_DIGITOS != 4'd0) begin
                  MONTO          <= acumulador;
                  MONTO_STB      <= 1'b1;
                  acumulador     <= '0;
                  NUM_DIGITOS    <= 4'd0;
                  MONTO_DESBORDE <= 1'b0;
               end
            end else if (tecla_codigo == TECLA_BORRAR) begin
               acumulador     <= '0;
               NUM_DIGITOS    <= 4'd0;
               MONTO_DESBORDE <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed testbench for teclado_cajero: PIN entry, bounce filtering,
// amount accumulation, digit limit, mode switching and reset behaviour.
module tb_teclado_cajero;

   logic        CLK;
   logic        RESET;
   logic        TECLA_VALIDA;
   logic [3:0]  TECLA;
   logic        MODO_MONTO;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        MONTO_DESBORDE;
   logic [3:0]  NUM_DIGITOS;

   int checks = 0;
   int errors = 0;

   teclado_cajero #(
      .DEBOUNCE_CICLOS  (4),
      .MAX_DIGITOS_MONTO(9)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .TECLA_VALIDA  (TECLA_VALIDA),
      .TECLA         (TECLA),
      .MODO_MONTO    (MODO_MONTO),
      .DIGITO        (DIGITO),
      .DIGITO_STB    (DIGITO_STB),
      .MONTO         (MONTO),
      .MONTO_STB     (MONTO_STB),
      .MONTO_DESBORDE(MONTO_DESBORDE),
      .NUM_DIGITOS   (NUM_DIGITOS)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Every edge is followed by #1 so outputs are read and inputs changed away from the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_key(input logic [3:0] code, input int hold, input int rel,
                            output int n_dig, output int n_mon, output int first_edge);
      n_dig = 0;
      n_mon = 0;
      first_edge = -1;
      TECLA = code;
      TECLA_VALIDA = 1'b1;
      for (int k = 0; k < hold + rel; k++) begin
         tick();
         if (DIGITO_STB) begin
            n_dig++;
            if (first_edge < 0) first_edge = k;
         end
         if (MONTO_STB) begin
            n_mon++;
            if (first_edge < 0) first_edge = k;
         end
         if (k == hold - 1) TECLA_VALIDA = 1'b0;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) tick();
      checks++;
      if (DIGITO !== 4'd0 || DIGITO_STB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_digito: got %0d/%0b expected 0/0", DIGITO, DIGITO_STB);
      end
      checks++;
      if (MONTO !== 32'd0 || MONTO_STB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_monto: got %0d/%0b expected 0/0", MONTO, MONTO_STB);
      end
      checks++;
      if (MONTO_DESBORDE !== 1'b0 || NUM_DIGITOS !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_acc: got %0b/%0d expected 0/0", MONTO_DESBORDE, NUM_DIGITOS);
      end
      RESET = 1'b0;
      tick();
   endtask

   task automatic test_pin_clean();
      logic [3:0] keys [4] = '{4'd3, 4'd5, 4'd6, 4'd6};
      int nd, nm, fe;
      MODO_MONTO = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pulse_key(keys[i], 6, 6, nd, nm, fe);
         checks++;
         if (nd !== 1 || nm !== 0) begin
            errors++;
            $display("[TB] FAIL pin_strobes[%0d]: got dig=%0d mon=%0d expected 1/0", i, nd, nm);
         end
         checks++;
         if (fe !== 3) begin
            errors++;
            $display("[TB] FAIL pin_latency[%0d]: got edge %0d expected 3", i, fe);
         end
         checks++;
         if (DIGITO !== keys[i]) begin
            errors++;
            $display("[TB] FAIL pin_digito[%0d]: got %0d expected %0d", i, DIGITO, keys[i]);
         end
      end
      pulse_key(4'hC, 6, 6, nd, nm, fe);
      checks++;
      if (nd !== 0 || nm !== 0 || DIGITO !== 4'd6) begin
         errors++;
         $display("[TB] FAIL pin_ignored: got dig=%0d mon=%0d DIGITO=%0d expected 0/0/6", nd, nm, DIGITO);
      end
   endtask

   task automatic test_bounce();
      int nd = 0;
      TECLA = 4'd7;
      for (int k = 0; k < 16; k++) begin
         TECLA_VALIDA = (k < 4) ? ~k[0] : (k < 10);
         tick();
         if (DIGITO_STB) nd++;
      end
      checks++;
      if (nd !== 1 || DIGITO !== 4'd7) begin
         errors++;
         $display("[TB] FAIL bounce_press: got %0d strobes DIGITO=%0d expected 1/7", nd, DIGITO);
      end
      nd = 0;
      TECLA = 4'd2;
      for (int k = 0; k < 18; k++) begin
         TECLA_VALIDA = (k < 6) || (k >= 8 && k < 12);
         tick();
         if (DIGITO_STB) nd++;
      end
      checks++;
      if (nd !== 1 || DIGITO !== 4'd2) begin
         errors++;
         $display("[TB] FAIL bounce_release: got %0d strobes DIGITO=%0d expected 1/2", nd, DIGITO);
      end
   endtask

   task automatic test_amount_commit();
      logic [3:0] keys [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
      int nd, nm, fe, tot_d;
      tot_d = 0;
      MODO_MONTO = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         pulse_key(keys[i], 6, 6, nd, nm, fe);
         tot_d += nd + nm;
      end
      checks++;
      if (tot_d !== 0 || NUM_DIGITOS !== 4'd5) begin
         errors++;
         $display("[TB] FAIL amount_digits: got strobes=%0d NUM=%0d expected 0/5", tot_d, NUM_DIGITOS);
      end
      pulse_key(4'hA, 6, 6, nd, nm, fe);
      checks++;
      if (nm !== 1 || nd !== 0 || fe !== 3) begin
         errors++;
         $display("[TB] FAIL amount_stb: got mon=%0d dig=%0d edge=%0d expected 1/0/3", nm, nd, fe);
      end
      checks++;
      if (MONTO !== 32'd10000 || NUM_DIGITOS !== 4'd0) begin
         errors++;
         $display("[TB] FAIL amount_value: got %0d NUM=%0d expected 10000/0", MONTO, NUM_DIGITOS);
      end
   endtask

   task automatic test_limit_and_clear();
      int nd, nm, fe;
      for (int i = 0; i < 9; i++) pulse_key(4'd9, 6, 6, nd, nm, fe);
      checks++;
      if (NUM_DIGITOS !== 4'd9 || MONTO_DESBORDE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL limit_nine: got NUM=%0d DESB=%0b expected 9/0", NUM_DIGITOS, MONTO_DESBORDE);
      end
      pulse_key(4'd9, 6, 6, nd, nm, fe);
      checks++;
      if (NUM_DIGITOS !== 4'd9 || MONTO_DESBORDE !== 1'b1) begin
         errors++;
         $display("[TB] FAIL limit_ten: got NUM=%0d DESB=%0b expected 9/1", NUM_DIGITOS, MONTO_DESBORDE);
      end
      pulse_key(4'hA, 6, 6, nd, nm, fe);
      checks++;
      if (nm !== 1 || MONTO !== 32'd999999999 || MONTO_DESBORDE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL limit_commit: got stb=%0d MONTO=%0d DESB=%0b expected 1/999999999/0",
                  nm, MONTO, MONTO_DESBORDE);
      end
      pulse_key(4'd4, 6, 6, nd, nm, fe);
      pulse_key(4'hB, 6, 6, nd, nm, fe);
      checks++;
      if (NUM_DIGITOS !== 4'd0) begin
         errors++;
         $display("[TB] FAIL borrar_num: got %0d expected 0", NUM_DIGITOS);
      end
      pulse_key(4'hA, 6, 6, nd, nm, fe);
      checks++;
      if (nm !== 0 || MONTO !== 32'd999999999) begin
         errors++;
         $display("[TB] FAIL borrar_enter: got stb=%0d MONTO=%0d expected 0/999999999", nm, MONTO);
      end
   endtask

   task automatic test_mode_switch();
      int nd, nm, fe;
      pulse_key(4'd7, 6, 6, nd, nm, fe);
      pulse_key(4'd0, 6, 6, nd, nm, fe);
      checks++;
      if (NUM_DIGITOS !== 4'd2) begin
         errors++;
         $display("[TB] FAIL switch_before: got NUM=%0d expected 2", NUM_DIGITOS);
      end
      MODO_MONTO = 1'b0;
      tick();
      checks++;
      if (NUM_DIGITOS !== 4'd0) begin
         errors++;
         $display("[TB] FAIL switch_clear: got NUM=%0d expected 0", NUM_DIGITOS);
      end
      pulse_key(4'hA, 6, 6, nd, nm, fe);
      checks++;
      if (nd !== 0 || nm !== 0 || MONTO !== 32'd999999999) begin
         errors++;
         $display("[TB] FAIL switch_enter: got dig=%0d mon=%0d MONTO=%0d expected 0/0/999999999", nd, nm, MONTO);
      end
      MODO_MONTO = 1'b1;
      pulse_key(4'hA, 6, 6, nd, nm, fe);
      checks++;
      if (nm !== 0) begin
         errors++;
         $display("[TB] FAIL switch_back_enter: got mon=%0d expected 0", nm);
      end
      MODO_MONTO = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      int fe = -1;
      TECLA = 4'd8;
      TECLA_VALIDA = 1'b1;
      repeat (3) tick();
      RESET = 1'b1;
      tick();
      if (DIGITO_STB) nd++;
      tick();
      if (DIGITO_STB) nd++;
      checks++;
      if (nd !== 0 || DIGITO !== 4'd0 || MONTO !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got stb=%0d DIGITO=%0d MONTO=%0d expected 0/0/0", nd, DIGITO, MONTO);
      end
      RESET = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (DIGITO_STB) begin
            nd++;
            if (fe < 0) fe = k;
         end
      end
      checks++;
      if (nd !== 1 || fe !== 3 || DIGITO !== 4'd8) begin
         errors++;
         $display("[TB] FAIL reset_held: got stb=%0d edge=%0d DIGITO=%0d expected 1/3/8", nd, fe, DIGITO);
      end
      TECLA_VALIDA = 1'b0;
      repeat (6) tick();
   endtask

   initial begin
      RESET        = 1'b1;
      TECLA_VALIDA = 1'b0;
      TECLA        = 4'd0;
      MODO_MONTO   = 1'b0;
      tick();
      test_reset();
      test_pin_clean();
      test_bounce();
      test_amount_commit();
      test_limit_and_clear();
      test_mode_switch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
